// File: rtl/mode_arbiter_pkg.sv
// Shared types and constants for the mode arbiter.
// Holds the FSM state encoding, channel-code helpers and RGB565 colours.
package mode_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_FRAME,
    ST_BLANK
  } state_e;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;

  // Channel code NUM_CH stands for "no channel" (default screen).
  function automatic int ch_none(input int num_ch);
    return num_ch;
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch < 1) ? 1 : $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/mode_arbiter_if.sv
// Switch, frame and per-channel display bundle for the mode arbiter.
// master drives the inputs and observes the arbitrated outputs.
interface mode_arbiter_if
  import mode_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SW_W   = 16
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [SW_W-1:0]      sw;
  logic                 frame_begin;
  logic [NUM_CH*16-1:0] led_ch;
  logic [NUM_CH*16-1:0] oled_ch;
  logic [15:0]          oled_init;
  logic [15:0]          led;
  logic [15:0]          oled_data;
  logic [NUM_CH-1:0]    ch_enable;
  logic [CH_W-1:0]      active_ch;
  logic                 mode_valid;

  modport master (
    output sw, frame_begin, led_ch, oled_ch, oled_init,
    input  led, oled_data, ch_enable, active_ch, mode_valid
  );

  modport slave (
    input  sw, frame_begin, led_ch, oled_ch, oled_init,
    output led, oled_data, ch_enable, active_ch, mode_valid
  );

endinterface

// File: rtl/mode_arbiter_sw_stability_filter.sv
// Password matcher plus debounce: a match code must hold for
// STABLE_CYCLES before a single-cycle commit pulse is issued.
module sw_stability_filter
  import mode_arbiter_pkg::*;
#(
  parameter int                       NUM_CH        = 4,
  parameter int                       SW_W          = 16,
  parameter logic [NUM_CH*SW_W-1:0]   PASSWORDS     = '0,
  parameter int                       STABLE_CYCLES = 1_000_000,
  localparam int                      CH_W          = ch_w(NUM_CH)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [SW_W-1:0] sw_i,
  output logic [CH_W-1:0] cand_o,
  output logic            commit_o
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] SAT =
    CW'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] PRE =
    CW'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
  localparam logic [CH_W-1:0] NONE = CH_W'(ch_none(NUM_CH));

  logic [CH_W-1:0] match;
  logic [CH_W-1:0] cand_q, cand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            commit_q, commit_d;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    match = NONE;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (sw_i == PASSWORDS[i*SW_W +: SW_W]) match = CH_W'(i);
    end
  end

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    commit_d = 1'b0;
    if (match != cand_q) begin
      cand_d   = match;
      cnt_d    = '0;
      commit_d = (STABLE_CYCLES <= 1);
    end else if (cnt_q != SAT) begin
      cnt_d    = cnt_q + CW'(1);
      commit_d = (cnt_q == PRE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cand_q   <= NONE;
      cnt_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
    end
  end

  assign cand_o   = cand_q;
  assign commit_o = commit_q;

endmodule

// File: rtl/mode_arbiter.sv
// Switch-selected channel arbiter for the LED/OLED display path.
// Mode changes wait for a frame start and blank whole frames.
module mode_arbiter
  import mode_arbiter_pkg::*;
#(
  parameter int                     NUM_CH        = 4,
  parameter int                     SW_W          = 16,
  parameter logic [NUM_CH*SW_W-1:0] PASSWORDS     = '0,
  parameter int                     STABLE_CYCLES = 1_000_000,
  parameter int                     BLANK_FRAMES  = 1,
  parameter logic [15:0]            BLANK_COLOR   = RGB565_BLACK
) (
  input  logic          clock_100mhz,
  input  logic          reset_n,
  mode_arbiter_if.slave bus
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam logic [CH_W-1:0] NONE = CH_W'(ch_none(NUM_CH));
  localparam int BW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
  localparam logic [BW-1:0] BLAST =
    BW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);
  localparam int LW = (SW_W < 16) ? SW_W : 16;

  logic [CH_W-1:0]   cand;
  logic              commit;
  state_e            state_q, state_d;
  logic [CH_W-1:0]   cur_q, cur_d;
  logic [CH_W-1:0]   tgt_q, tgt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [15:0]       led_q, led_d;
  logic [15:0]       oled_q, oled_d;
  logic [NUM_CH-1:0] chen;

  sw_stability_filter #(
    .NUM_CH        (NUM_CH),
    .SW_W          (SW_W),
    .PASSWORDS     (PASSWORDS),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk_i    (clock_100mhz),
    .rst_n_i  (reset_n),
    .sw_i     (bus.sw),
    .cand_o   (cand),
    .commit_o (commit)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    bcnt_d  = bcnt_q;
    if (commit) tgt_d = cand;
    unique case (state_q)
      ST_RUN: begin
        if (commit && cand != cur_q) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (commit && cand == cur_q) begin
          state_d = ST_RUN;
        end else if (bus.frame_begin) begin
          if (BLANK_FRAMES == 0) begin
            cur_d   = tgt_d;
            state_d = ST_RUN;
          end else begin
            bcnt_d  = '0;
            state_d = ST_BLANK;
          end
        end
      end
      ST_BLANK: begin
        // Late commits only retarget; the frame count keeps running.
        if (bus.frame_begin) begin
          if (bcnt_q == BLAST) begin
            cur_d   = tgt_d;
            bcnt_d  = '0;
            state_d = ST_RUN;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    led_d           = '0;
    led_d[LW-1:0]   = bus.sw[LW-1:0];
    oled_d          = bus.oled_init;
    chen            = '0;
    if (state_q == ST_BLANK) begin
      led_d  = '0;
      oled_d = BLANK_COLOR;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cur_q == CH_W'(i)) begin
          led_d   = bus.led_ch[16*i +: 16];
          oled_d  = bus.oled_ch[16*i +: 16];
          chen[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_100mhz) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      cur_q   <= NONE;
      tgt_q   <= NONE;
      bcnt_q  <= '0;
      led_q   <= '0;
      oled_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      bcnt_q  <= bcnt_d;
      led_q   <= led_d;
      oled_q  <= oled_d;
    end
  end

  assign bus.led        = led_q;
  assign bus.oled_data  = oled_q;
  assign bus.ch_enable  = chen;
  assign bus.active_ch  = cur_q;
  assign bus.mode_valid = (state_q == ST_RUN) && (cur_q != NONE);

endmodule

// File: tb/tb_mode_arbiter.sv
// Directed bench for mode_arbiter: vector table plus glitch sequences.
// NUM_CH=4, ch1=2265, ch3=8195, STABLE_CYCLES=4, BLANK_FRAMES=1.
module tb_mode_arbiter;
  import mode_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] PW = {16'h8195, 16'h4444, 16'h2265, 16'h1111};
  localparam logic [15:0] INIT = 16'hCAFE;
  localparam logic [15:0] L1 = 16'hA111;
  localparam logic [15:0] O1 = 16'hB111;
  localparam logic [15:0] L3 = 16'hA333;
  localparam logic [15:0] O3 = 16'hB333;

  mode_arbiter_if #(.NUM_CH(4), .SW_W(16)) bus ();

  mode_arbiter #(
    .NUM_CH        (4),
    .SW_W          (16),
    .PASSWORDS     (PW),
    .STABLE_CYCLES (4),
    .BLANK_FRAMES  (1),
    .BLANK_COLOR   (16'h0000)
  ) dut (
    .clock_100mhz (clk),
    .reset_n      (rst_n),
    .bus          (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic [15:0] sw;
    logic        fb;
    logic [15:0] led;
    logic [15:0] oled;
    logic [3:0]  chen;
    logic [2:0]  act;
    logic        vld;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic addn(input int n, input logic r, input logic [15:0] s,
                      input logic f, input logic [15:0] l,
                      input logic [15:0] o, input logic [3:0] c,
                      input logic [2:0] a, input logic m);
    vec_t t;
    t.rst = r; t.sw = s; t.fb = f; t.led = l; t.oled = o;
    t.chen = c; t.act = a; t.vld = m;
    for (int k = 0; k < n; k++) vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic [15:0] s, input logic f);
    @(negedge clk);
    rst_n = r;
    bus.sw = s;
    bus.frame_begin = f;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] l,
                       input logic [15:0] o, input logic [3:0] c,
                       input logic [2:0] a, input logic m);
    logic [39:0] got, exp;
    got = {bus.led, bus.oled_data, bus.ch_enable, bus.active_ch,
           bus.mode_valid};
    exp = {l, o, c, a, m};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got led=%h oled=%h en=%b ch=%0d vld=%b want led=%h oled=%h en=%b ch=%0d vld=%b",
               nm, bus.led, bus.oled_data, bus.ch_enable, bus.active_ch,
               bus.mode_valid, l, o, c, a, m);
    end
  endtask

  initial begin
    bus.sw          = 16'h00F0;
    bus.frame_begin = 1'b0;
    bus.led_ch      = {16'hA333, 16'hA222, 16'hA111, 16'hA000};
    bus.oled_ch     = {16'hB333, 16'hB222, 16'hB111, 16'hB000};
    bus.oled_init   = INIT;

    // reset, default mode shows switches
    addn(1, 0, 16'h00F0, 0, 16'h0000, 16'h0000, 4'b0000, 3'd4, 0);
    addn(4, 1, 16'h00F0, 0, 16'h00F0, INIT, 4'b0000, 3'd4, 0);
    // short password pulse: no commit
    addn(2, 1, 16'h2265, 0, 16'h2265, INIT, 4'b0000, 3'd4, 0);
    addn(2, 1, 16'h00F0, 0, 16'h00F0, INIT, 4'b0000, 3'd4, 0);
    // ch1 qualifies; frame_begin on the commit cycle is ignored
    addn(4, 1, 16'h2265, 0, 16'h2265, INIT, 4'b0000, 3'd4, 0);
    addn(1, 1, 16'h2265, 1, 16'h2265, INIT, 4'b0000, 3'd4, 0);
    addn(1, 1, 16'h2265, 0, 16'h2265, INIT, 4'b0000, 3'd4, 0);
    addn(1, 1, 16'h2265, 1, 16'h2265, INIT, 4'b0000, 3'd4, 0);
    addn(1, 1, 16'h2265, 0, 16'h0000, 16'h0000, 4'b0000, 3'd4, 0);
    addn(1, 1, 16'h2265, 1, 16'h0000, 16'h0000, 4'b0010, 3'd1, 1);
    addn(1, 1, 16'h2265, 0, L1, O1, 4'b0010, 3'd1, 1);
    // toward ch3, then back to ch1 before any frame: no blank
    addn(4, 1, 16'h8195, 0, L1, O1, 4'b0010, 3'd1, 1);
    addn(1, 1, 16'h8195, 0, L1, O1, 4'b0010, 3'd1, 0);
    addn(4, 1, 16'h2265, 0, L1, O1, 4'b0010, 3'd1, 0);
    addn(1, 1, 16'h2265, 0, L1, O1, 4'b0010, 3'd1, 1);
    addn(1, 1, 16'h2265, 1, L1, O1, 4'b0010, 3'd1, 1);
    // toward ch0, retargeted to ch3 while blanking
    addn(4, 1, 16'h1111, 0, L1, O1, 4'b0010, 3'd1, 1);
    addn(1, 1, 16'h1111, 0, L1, O1, 4'b0010, 3'd1, 0);
    addn(1, 1, 16'h1111, 1, L1, O1, 4'b0000, 3'd1, 0);
    addn(5, 1, 16'h8195, 0, 16'h0000, 16'h0000, 4'b0000, 3'd1, 0);
    addn(1, 1, 16'h8195, 1, 16'h0000, 16'h0000, 4'b1000, 3'd3, 1);
    addn(1, 1, 16'h8195, 0, L3, O3, 4'b1000, 3'd3, 1);
    // reset during blank, then full requalification
    addn(4, 1, 16'h2265, 0, L3, O3, 4'b1000, 3'd3, 1);
    addn(1, 1, 16'h2265, 0, L3, O3, 4'b1000, 3'd3, 0);
    addn(1, 1, 16'h2265, 1, L3, O3, 4'b0000, 3'd3, 0);
    addn(1, 0, 16'h2265, 0, 16'h0000, 16'h0000, 4'b0000, 3'd4, 0);
    addn(4, 1, 16'h2265, 0, 16'h2265, INIT, 4'b0000, 3'd4, 0);
    addn(2, 1, 16'h2265, 1, 16'h2265, INIT, 4'b0000, 3'd4, 0);
    addn(1, 1, 16'h2265, 0, 16'h0000, 16'h0000, 4'b0000, 3'd4, 0);
    addn(1, 1, 16'h2265, 1, 16'h0000, 16'h0000, 4'b0010, 3'd1, 1);
    addn(1, 1, 16'h2265, 0, L1, O1, 4'b0010, 3'd1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].sw, vecs[i].fb);
      check($sformatf("vec%0d", i), vecs[i].led, vecs[i].oled,
            vecs[i].chen, vecs[i].act, vecs[i].vld);
    end

    // unstable switch wiggles while waiting and blanking
    repeat (5) drive(1, 16'h8195, 0);
    check("wait_entry", L1, O1, 4'b0010, 3'd1, 0);
    repeat (2) drive(1, 16'h1111, 0);
    repeat (5) drive(1, 16'h8195, 0);
    check("wait_glitch", L1, O1, 4'b0010, 3'd1, 0);
    drive(1, 16'h8195, 1);
    check("blank_entry", L1, O1, 4'b0000, 3'd1, 0);
    repeat (2) drive(1, 16'h1111, 0);
    repeat (2) drive(1, 16'h8195, 0);
    check("blank_glitch", 16'h0000, 16'h0000, 4'b0000, 3'd1, 0);
    drive(1, 16'h8195, 1);
    check("blank_exit", 16'h0000, 16'h0000, 4'b1000, 3'd3, 1);
    drive(1, 16'h8195, 0);
    check("run_ch3", L3, O3, 4'b1000, 3'd3, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_arbiter.md
MODE_ARBITER -- requirements
Module: mode_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4: number of selectable user channels.
REQ-002 Parameter SW_W, default 16: switch/password width.
REQ-003 Parameter PASSWORDS, default 0 (NUM_CH*SW_W bits): packed password table; slice i is the password of channel i.
REQ-004 Parameter STABLE_CYCLES, default 1_000_000: cycles a switch pattern must hold before it is accepted (10 ms at 100 MHz).
REQ-005 Parameter BLANK_FRAMES, default 1: number of blank OLED frames inserted on each mode change.
REQ-006 Parameter BLANK_COLOR, default 16'h0000: RGB565 colour driven while blanking.
REQ-007 clock_100mhz  in  1  sole clock; all logic on the rising edge.
REQ-008 reset_n  in  1  synchronous, active-low reset.
REQ-009 sw  in  SW_W  raw slide-switch value.
REQ-010 frame_begin  in  1  one-cycle pulse at each OLED frame start, already in the clock_100mhz domain.
REQ-011 led_ch  in  NUM_CH*16  packed per-channel LED words.
REQ-012 oled_ch  in  NUM_CH*16  packed per-channel pixel words.
REQ-013 oled_init  in  16  default-screen pixel word.
REQ-014 led  out  16  registered LED output.
REQ-015 oled_data  out  16  registered pixel output.
REQ-016 ch_enable  out  NUM_CH  one-hot run enable; 0 holds a channel in its own reset.
REQ-017 active_ch  out  clog2(NUM_CH+1)  current channel; value NUM_CH means NONE (default mode).
REQ-018 mode_valid  out  1  high when active_ch != NONE and the FSM is in RUN.

Function
REQ-019 Match code: lowest index i with sw == PASSWORDS slice i, else NONE; purely combinational.
REQ-020 Filter: candidate register plus counter; a match code differing from candidate loads candidate and clears the counter; otherwise the counter increments, saturating at STABLE_CYCLES-1.
REQ-021 Commit: a single-cycle commit pulse fires when the counter first reaches STABLE_CYCLES-1; target <= candidate.
REQ-022 FSM states: RUN, WAIT_FRAME, BLANK.
REQ-023 RUN: on commit with target != current -> WAIT_FRAME; commit equal to current is ignored.
REQ-024 WAIT_FRAME: outputs still follow current; a new commit overwrites target; a commit equal to current -> RUN; on frame_begin -> BLANK (or, if BLANK_FRAMES == 0, current <= target and -> RUN).
REQ-025 BLANK: oled_data = BLANK_COLOR, led = 0, ch_enable = 0; counts frame_begin pulses; on the BLANK_FRAMES-th pulse current <= target and -> RUN; new commits update target only and do not restart the count.
REQ-026 Output select, RUN/WAIT_FRAME: current == NONE -> led = sw[15:0], oled_data = oled_init; else the slices of led_ch/oled_ch at index current.
REQ-027 ch_enable is the one-hot of current in RUN and WAIT_FRAME, all-zero when current == NONE or in BLANK.
REQ-028 Latency: led/oled_data are registered exactly one cycle after the selected inputs.
REQ-029 frame_begin coinciding with commit in RUN is not consumed; the switch waits for the next frame_begin.
REQ-030 sw change during WAIT_FRAME/BLANK that does not stabilise has no effect.

Reset
REQ-031 While reset_n is low at a clock edge: state = RUN, current = target = candidate = NONE, counters = 0, led = 0, oled_data = 0, ch_enable = 0, active_ch = NUM_CH, mode_valid = 0.
REQ-032 Reset mid-BLANK or mid-WAIT_FRAME abandons the switch; after release the filter must requalify the pattern for the full STABLE_CYCLES.

Structure
REQ-033 Shared package holds the FSM state enum, the NONE encoding helper and the RGB565 colour constants.
REQ-034 One sub-module, sw_stability_filter (REQ-019 to REQ-021), outputs candidate and commit; FSM and output muxing stay in mode_arbiter.

Verification (NUM_CH=4, ch1=16'h2265, ch3=16'h8195, STABLE_CYCLES=4, BLANK_FRAMES=1)
REQ-035 Reset, then sw=16'h00F0 -> led=16'h00F0, oled_data=oled_init, active_ch=4, ch_enable=0.
REQ-036 sw=16'h2265 held 4 cycles, then frame_begin twice -> BLANK (oled_data=0, led=0) between pulses; after the 2nd pulse active_ch=1, ch_enable=4'b0010, led=led_ch[31:16].
REQ-037 sw=16'h2265 for 2 cycles, then back -> no commit, state stays RUN, outputs unchanged.
REQ-038 In WAIT_FRAME toward ch1, sw returns to the current channel and stabilises before frame_begin -> back to RUN, no blank frame.
REQ-039 In BLANK toward ch1, sw=16'h8195 stabilises -> on frame_begin active_ch=3, ch_enable=4'b1000.
REQ-040 reset_n low during BLANK -> next cycle all outputs at reset values; with sw still 16'h2265, recommit occurs only after 4 more cycles.
